// File: rtl/ext_bus_ctrl.sv
// ext_bus_ctrl
// ----------------------------------------------------------------------------
// Sequences and arbitrates the CPU core's 8-bit external memory bus between
// instruction fetch and data load/store. Each 16-bit access goes out as a
// command byte ({6'b0, is_fetch, we}), address hi/lo, then either two write
// data bytes (sent) or two read data bytes (received via in_bus).
//
// Handshakes: a requester raises *_req with its address/data stable and holds
// them until its *_done pulse. *_gnt pulses in the first CMD cycle, *_done in
// the single DONE cycle. On the external side, a send state advances on an
// edge with ard_receive_ready=1 (out_bus taken). A read state advances on an
// edge with ard_data_ready=1, when in_bus is captured. Ready inputs are
// ignored in IDLE and DONE.
//
// Ports
//   clk, rst_n                      clock, synchronous active-low reset
//   fetch_req/addr, fetch_gnt/done  instruction fetch requester
//   mem_req/we/addr/wdata,
//   mem_gnt/done                    data load/store requester
//   rdata                           last successfully read 16-bit word
//   err                             pulses with done when a wait timed out
//   in_bus, ard_data_ready          external read byte and its valid
//   ard_receive_ready, out_bus      external accept and outgoing byte
//   bus_pc, bus_mar, bus_mdr        transaction / byte-kind tags
//   busy                            controller not idle
//
// Parameters
//   STARVE_LIMIT    mem grants allowed while fetch waits before fetch is forced
//   TIMEOUT_CYCLES  stalled cycles per byte phase before abort
//
// Build option: define BUS_TIMEOUT_EN to enable the per-phase wait timeout.
// Without it waits are unbounded and err stays 0.
// ----------------------------------------------------------------------------
module ext_bus_ctrl #(
   parameter int STARVE_LIMIT   = 4,
   parameter int TIMEOUT_CYCLES = 255
) (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        fetch_req,
   input  logic [15:0] fetch_addr,
   output logic        fetch_gnt,
   output logic        fetch_done,
   input  logic        mem_req,
   input  logic        mem_we,
   input  logic [15:0] mem_addr,
   input  logic [15:0] mem_wdata,
   output logic        mem_gnt,
   output logic        mem_done,
   output logic [15:0] rdata,
   output logic        err,
   input  logic [7:0]  in_bus,
   input  logic        ard_data_ready,
   input  logic        ard_receive_ready,
   output logic [7:0]  out_bus,
   output logic        bus_pc,
   output logic        bus_mar,
   output logic        bus_mdr,
   output logic        busy
);

   localparam int            SW         = $clog2(STARVE_LIMIT + 1);
   localparam logic [SW-1:0] STARVE_MAX = SW'(STARVE_LIMIT);

   typedef enum logic [3:0] {
      IDLE    = 4'd0,
      CMD     = 4'd1,
      ADDR_HI = 4'd2,
      ADDR_LO = 4'd3,
      WR_HI   = 4'd4,
      WR_LO   = 4'd5,
      RD_HI   = 4'd6,
      RD_LO   = 4'd7,
      DONE    = 4'd8
   } state_t;

   state_t        state;
   state_t        next_state;

   // Transaction latched at grant time
   logic [15:0]   lat_addr;
   logic [15:0]   lat_wdata;
   logic          lat_we;
   logic          lat_fetch;
   logic [7:0]    shadow_hi;
   logic [SW-1:0] starve_cnt;

   logic          fetch_wins;
   logic          grant_fetch;
   logic          grant_mem;
   logic          timeout_hit;

   // Transaction fields as seen by the output logic: in IDLE the latches do
   // not hold the new winner yet, so take it straight from the request ports.
   logic [15:0]   cur_addr;
   logic [15:0]   cur_wdata;
   logic          cur_we;
   logic          cur_fetch;

   // Values the output registers load on the next edge
   logic [7:0]    nxt_out_bus;
   logic          nxt_mar;
   logic          nxt_mdr;
   logic          nxt_pc;
   logic          nxt_fetch_gnt;
   logic          nxt_mem_gnt;
   logic          nxt_fetch_done;
   logic          nxt_mem_done;
   logic          nxt_err;
   logic          nxt_busy;

   // mem has priority unless fetch has already waited out STARVE_LIMIT grants
   assign fetch_wins = fetch_req && (!mem_req || (starve_cnt == STARVE_MAX));

`ifdef BUS_TIMEOUT_EN
   localparam int            WW        = (TIMEOUT_CYCLES > 255) ? $clog2(TIMEOUT_CYCLES + 1) : 8;
   localparam logic [WW-1:0] WAIT_LAST = WW'(TIMEOUT_CYCLES - 1);

   logic [WW-1:0] wait_cnt;
   logic          stalled;

   always_comb begin
      stalled = 1'b0;
      case (state)
         CMD, ADDR_HI, ADDR_LO, WR_HI, WR_LO: stalled = !ard_receive_ready;
         RD_HI, RD_LO:                        stalled = !ard_data_ready;
         default:                             stalled = 1'b0;
      endcase
   end

   // Counts stalled cycles within one byte phase; any state change restarts it
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         wait_cnt <= '0;
      end else if (next_state != state) begin
         wait_cnt <= '0;
      end else if (stalled) begin
         wait_cnt <= wait_cnt + WW'(1);
      end
   end
`endif

   // ------------------------------------------------------------------
   // State register
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // ------------------------------------------------------------------
   // Next-state logic
   // ------------------------------------------------------------------
   always_comb begin
      next_state  = state;
      grant_fetch = 1'b0;
      grant_mem   = 1'b0;
      timeout_hit = 1'b0;
      case (state)
         IDLE: begin
            if (fetch_req || mem_req) begin
               next_state  = CMD;
               grant_fetch = fetch_wins;
               grant_mem   = !fetch_wins;
            end
         end
         CMD:     if (ard_receive_ready) next_state = ADDR_HI;
         ADDR_HI: if (ard_receive_ready) next_state = ADDR_LO;
         ADDR_LO: if (ard_receive_ready) next_state = lat_we ? WR_HI : RD_HI;
         WR_HI:   if (ard_receive_ready) next_state = WR_LO;
         WR_LO:   if (ard_receive_ready) next_state = DONE;
         RD_HI:   if (ard_data_ready)    next_state = RD_LO;
         RD_LO:   if (ard_data_ready)    next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
`ifdef BUS_TIMEOUT_EN
      if (stalled && (wait_cnt == WAIT_LAST)) begin
         next_state  = DONE;
         timeout_hit = 1'b1;
      end
`endif
   end

   // ------------------------------------------------------------------
   // Output logic: decodes next_state so the registered outputs line up
   // with the state they describe.
   // ------------------------------------------------------------------
   always_comb begin
      if (state == IDLE) begin
         cur_fetch = fetch_wins;
         cur_addr  = fetch_wins ? fetch_addr : mem_addr;
         cur_wdata = fetch_wins ? 16'h0000 : mem_wdata;
         cur_we    = fetch_wins ? 1'b0 : mem_we;
      end else begin
         cur_fetch = lat_fetch;
         cur_addr  = lat_addr;
         cur_wdata = lat_wdata;
         cur_we    = lat_we;
      end

      nxt_out_bus    = 8'h00;
      nxt_mar        = 1'b0;
      nxt_mdr        = 1'b0;
      nxt_pc         = 1'b0;
      nxt_fetch_done = 1'b0;
      nxt_mem_done   = 1'b0;
      nxt_err        = 1'b0;
      nxt_fetch_gnt  = grant_fetch;
      nxt_mem_gnt    = grant_mem;
      nxt_busy       = (next_state != IDLE);

      case (next_state)
         CMD: begin
            nxt_out_bus = {6'b0, cur_fetch, cur_we};
            nxt_mar     = 1'b1;
            nxt_mdr     = 1'b1;
            nxt_pc      = cur_fetch;
         end
         ADDR_HI: begin
            nxt_out_bus = cur_addr[15:8];
            nxt_mar     = 1'b1;
            nxt_pc      = cur_fetch;
         end
         ADDR_LO: begin
            nxt_out_bus = cur_addr[7:0];
            nxt_mar     = 1'b1;
            nxt_pc      = cur_fetch;
         end
         WR_HI: begin
            nxt_out_bus = cur_wdata[15:8];
            nxt_mdr     = 1'b1;
            nxt_pc      = cur_fetch;
         end
         WR_LO: begin
            nxt_out_bus = cur_wdata[7:0];
            nxt_mdr     = 1'b1;
            nxt_pc      = cur_fetch;
         end
         RD_HI, RD_LO: begin
            nxt_pc = cur_fetch;
         end
         DONE: begin
            nxt_fetch_done = lat_fetch;
            nxt_mem_done   = !lat_fetch;
            nxt_err        = timeout_hit;
         end
         default: begin
            nxt_out_bus = 8'h00;
         end
      endcase
   end

   // ------------------------------------------------------------------
   // Datapath, arbitration bookkeeping and output registers
   // ------------------------------------------------------------------
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         lat_addr   <= '0;
         lat_wdata  <= '0;
         lat_we     <= 1'b0;
         lat_fetch  <= 1'b0;
         shadow_hi  <= '0;
         starve_cnt <= '0;
         rdata      <= '0;
         out_bus    <= '0;
         bus_mar    <= 1'b0;
         bus_mdr    <= 1'b0;
         bus_pc     <= 1'b0;
         fetch_gnt  <= 1'b0;
         mem_gnt    <= 1'b0;
         fetch_done <= 1'b0;
         mem_done   <= 1'b0;
         err        <= 1'b0;
         busy       <= 1'b0;
      end else begin
         if (grant_fetch || grant_mem) begin
            lat_addr  <= cur_addr;
            lat_wdata <= cur_wdata;
            lat_we    <= cur_we;
            lat_fetch <= cur_fetch;
         end

         if (grant_fetch) begin
            starve_cnt <= '0;
         end else if (grant_mem && fetch_req && (starve_cnt != STARVE_MAX)) begin
            starve_cnt <= starve_cnt + SW'(1);
         end

         if ((state == RD_HI) && ard_data_ready) begin
            shadow_hi <= in_bus;
         end
         // Only a completed low-byte capture updates rdata; a timeout abort
         // leaves the previous word in place.
         if ((state == RD_LO) && ard_data_ready) begin
            rdata <= {shadow_hi, in_bus};
         end

         out_bus    <= nxt_out_bus;
         bus_mar    <= nxt_mar;
         bus_mdr    <= nxt_mdr;
         bus_pc     <= nxt_pc;
         fetch_gnt  <= nxt_fetch_gnt;
         mem_gnt    <= nxt_mem_gnt;
         fetch_done <= nxt_fetch_done;
         mem_done   <= nxt_mem_done;
         err        <= nxt_err;
         busy       <= nxt_busy;
      end
   end

endmodule

// File: tb/tb_ext_bus_ctrl.sv
// tb_ext_bus_ctrl
// Directed bench for ext_bus_ctrl (default build): reset state, store, fetch
// with read-ready gaps, send stall, fetch-starvation arbitration and reset
// during a transaction. Cycle 1 is the grant cycle of each transaction.
module tb_ext_bus_ctrl;

   logic        clk;
   logic        rst_n;
   logic        fetch_req;
   logic [15:0] fetch_addr;
   logic        fetch_gnt;
   logic        fetch_done;
   logic        mem_req;
   logic        mem_we;
   logic [15:0] mem_addr;
   logic [15:0] mem_wdata;
   logic        mem_gnt;
   logic        mem_done;
   logic [15:0] rdata;
   logic        err;
   logic [7:0]  in_bus;
   logic        ard_data_ready;
   logic        ard_receive_ready;
   logic [7:0]  out_bus;
   logic        bus_pc;
   logic        bus_mar;
   logic        bus_mdr;
   logic        busy;

   int checks = 0;
   int errors = 0;
   logic [31:0] exp_q[$];

   ext_bus_ctrl dut (
      .clk               (clk),
      .rst_n             (rst_n),
      .fetch_req         (fetch_req),
      .fetch_addr        (fetch_addr),
      .fetch_gnt         (fetch_gnt),
      .fetch_done        (fetch_done),
      .mem_req           (mem_req),
      .mem_we            (mem_we),
      .mem_addr          (mem_addr),
      .mem_wdata         (mem_wdata),
      .mem_gnt           (mem_gnt),
      .mem_done          (mem_done),
      .rdata             (rdata),
      .err               (err),
      .in_bus            (in_bus),
      .ard_data_ready    (ard_data_ready),
      .ard_receive_ready (ard_receive_ready),
      .out_bus           (out_bus),
      .bus_pc            (bus_pc),
      .bus_mar           (bus_mar),
      .bus_mdr           (bus_mdr),
      .busy              (busy)
   );

   // ---------------- clock / reset ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ---------------- helpers ----------------
   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      if (obs !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   // Advance one clock and settle past the edge before sampling/driving
   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [31:0] bw(input logic mar, input logic mdr, input logic pc,
                                      input logic [7:0] b);
      return {21'b0, mar, mdr, pc, b};
   endfunction

   function automatic logic [31:0] bus_word();
      return {21'b0, bus_mar, bus_mdr, bus_pc, out_bus};
   endfunction

   // {fetch_gnt, fetch_done, mem_gnt, mem_done, err, bus_pc, bus_mar, bus_mdr, busy, out_bus, rdata}
   function automatic logic [31:0] all_outs();
      return {fetch_gnt, fetch_done, mem_gnt, mem_done, err, bus_pc, bus_mar, bus_mdr,
              busy, out_bus, rdata[6:0]} | {16'b0, rdata};
   endfunction

   // ---------------- driver tasks ----------------
   // Store with receive_ready held high: bytes on cycles 1-5, done on cycle 6
   task automatic run_write(input logic [15:0] a, input logic [15:0] d, input string tag);
      mem_we            = 1'b1;
      mem_addr          = a;
      mem_wdata         = d;
      mem_req           = 1'b1;
      ard_receive_ready = 1'b1;
      exp_q.push_back(bw(1'b1, 1'b1, 1'b0, 8'h01));
      exp_q.push_back(bw(1'b1, 1'b0, 1'b0, a[15:8]));
      exp_q.push_back(bw(1'b1, 1'b0, 1'b0, a[7:0]));
      exp_q.push_back(bw(1'b0, 1'b1, 1'b0, d[15:8]));
      exp_q.push_back(bw(1'b0, 1'b1, 1'b0, d[7:0]));
      for (int c = 1; c <= 5; c++) begin
         step();
         if (c == 1) check({tag, "_gnt"}, {30'b0, fetch_gnt, mem_gnt}, 32'd1);
         if (c == 2) check({tag, "_gnt_pulse"}, {31'b0, mem_gnt}, 32'd0);
         check($sformatf("%s_byte%0d", tag, c), bus_word(), exp_q.pop_front());
      end
      step();
      check({tag, "_done"}, {29'b0, fetch_done, mem_done, err}, 32'b010);
      check({tag, "_done_bus"}, bus_word(), 32'd0);
      mem_req = 1'b0;
      step();
      check({tag, "_idle"}, {30'b0, busy, mem_done}, 32'd0);
   endtask

   // ---------------- stimulus + scoreboard ----------------
   initial begin
      int ng;
      int seen;
      int guard;

      rst_n             = 1'b0;
      fetch_req         = 1'b0;
      fetch_addr        = '0;
      mem_req           = 1'b0;
      mem_we            = 1'b0;
      mem_addr          = '0;
      mem_wdata         = '0;
      in_bus            = '0;
      ard_data_ready    = 1'b0;
      ard_receive_ready = 1'b0;

      // Reset state
      repeat (3) step();
      check("reset_outs", all_outs(), 32'd0);
      rst_n = 1'b1;
      step();
      check("idle_no_req", all_outs(), 32'd0);

      // Store 0x1234 <= 0xBEEF
      run_write(16'h1234, 16'hBEEF, "store");
      check("store_rdata", {16'b0, rdata}, 32'h0);

      // Fetch 0x0040 with gaps on ard_data_ready; data_ready high and in_bus
      // junk during the send phase must be ignored.
      fetch_addr        = 16'h0040;
      fetch_req         = 1'b1;
      ard_receive_ready = 1'b1;
      ard_data_ready    = 1'b1;
      in_bus            = 8'h99;
      exp_q.push_back(bw(1'b1, 1'b1, 1'b1, 8'h02));
      exp_q.push_back(bw(1'b1, 1'b0, 1'b1, 8'h00));
      exp_q.push_back(bw(1'b1, 1'b0, 1'b1, 8'h40));
      repeat (4) exp_q.push_back(bw(1'b0, 1'b0, 1'b1, 8'h00));
      for (int c = 1; c <= 7; c++) begin
         step();
         if (c == 1) check("fetch_gnt", {30'b0, fetch_gnt, mem_gnt}, 32'b10);
         check($sformatf("fetch_bus%0d", c), bus_word(), exp_q.pop_front());
         case (c)
            3: begin ard_data_ready = 1'b0; in_bus = 8'h11; end
            5: begin ard_data_ready = 1'b1; in_bus = 8'hA5; end
            6: begin ard_data_ready = 1'b0; in_bus = 8'hFF; end
            7: begin
               check("fetch_not_done_yet", {31'b0, fetch_done}, 32'd0);
               ard_data_ready = 1'b1;
               in_bus         = 8'h3C;
            end
            default: ;
         endcase
      end
      step();
      check("fetch_done", {28'b0, fetch_done, mem_done, err, busy}, 32'b1001);
      check("fetch_rdata", {16'b0, rdata}, 32'hA53C);
      check("fetch_done_bus", bus_word(), 32'd0);
      fetch_req      = 1'b0;
      ard_data_ready = 1'b0;
      step();
      check("fetch_idle", {30'b0, busy, fetch_done}, 32'd0);
      check("fetch_rdata_hold", {16'b0, rdata}, 32'hA53C);

      // Load 0x1234 with a 3-cycle receive stall in ADDR_LO
      mem_we            = 1'b0;
      mem_addr          = 16'h1234;
      mem_req           = 1'b1;
      ard_receive_ready = 1'b1;
      ard_data_ready    = 1'b1;
      in_bus            = 8'h5A;
      for (int c = 1; c <= 9; c++) begin
         step();
         case (c)
            1: check("stall_cmd", bus_word(), bw(1'b1, 1'b1, 1'b0, 8'h00));
            2: check("stall_ahi", bus_word(), bw(1'b1, 1'b0, 1'b0, 8'h12));
            3, 4, 5, 6: check($sformatf("stall_alo%0d", c), bus_word(), bw(1'b1, 1'b0, 1'b0, 8'h34));
            7: check("stall_rdhi", bus_word(), 32'd0);
            8: check("stall_early_done", {31'b0, mem_done}, 32'd0);
            9: begin
               check("stall_done", {29'b0, fetch_done, mem_done, err}, 32'b010);
               check("stall_rdata", {16'b0, rdata}, 32'h5AC3);
            end
            default: ;
         endcase
         if (c == 3) ard_receive_ready = 1'b0;
         if (c == 6) ard_receive_ready = 1'b1;
         if (c == 8) in_bus = 8'hC3;
      end
      mem_req = 1'b0;
      step();
      check("stall_idle", {31'b0, busy}, 32'd0);

      // Arbitration: both requesters held; expect M M M M F M M M M F
      mem_we            = 1'b1;
      mem_addr          = 16'h2000;
      mem_wdata         = 16'h0000;
      fetch_addr        = 16'h0100;
      ard_receive_ready = 1'b1;
      ard_data_ready    = 1'b1;
      in_bus            = 8'h77;
      repeat (4) exp_q.push_back(32'b01);
      exp_q.push_back(32'b10);
      repeat (4) exp_q.push_back(32'b01);
      exp_q.push_back(32'b10);
      mem_req   = 1'b1;
      fetch_req = 1'b1;
      ng        = 0;
      guard     = 0;
      while ((ng < 10) && (guard < 200)) begin
         step();
         guard++;
         if (mem_gnt || fetch_gnt) begin
            if (ng == 4) check("arb_rdata_hold", {16'b0, rdata}, 32'h5AC3);
            check($sformatf("arb_gnt%0d", ng), {30'b0, fetch_gnt, mem_gnt}, exp_q.pop_front());
            ng++;
         end
      end
      mem_req   = 1'b0;
      fetch_req = 1'b0;
      check("arb_count", ng, 10);
      seen  = 0;
      guard = 0;
      while (busy && (guard < 20)) begin
         if (fetch_done) seen = 1;
         step();
         guard++;
      end
      check("arb_tail_done", seen, 1);
      check("arb_idle", {31'b0, busy}, 32'd0);
      check("arb_rdata", {16'b0, rdata}, 32'h7777);

      // Reset during WR_HI
      mem_we            = 1'b1;
      mem_addr          = 16'h0F0F;
      mem_wdata         = 16'h1357;
      mem_req           = 1'b1;
      ard_receive_ready = 1'b1;
      for (int c = 1; c <= 4; c++) step();
      check("rst_wrhi", bus_word(), bw(1'b0, 1'b1, 1'b0, 8'h13));
      rst_n   = 1'b0;
      mem_req = 1'b0;
      step();
      check("rst_mid_outs", all_outs(), 32'd0);
      rst_n = 1'b1;
      for (int c = 0; c < 3; c++) begin
         step();
         check($sformatf("rst_no_done%0d", c), {30'b0, busy, mem_done}, 32'd0);
      end
      run_write(16'hA55A, 16'h0FF0, "reissue");

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/ext_bus_ctrl.md
Name: ext_bus_ctrl

Overview:
Sequences and arbitrates the CPU core's 8-bit external (Arduino-side) memory bus. Two requesters share the bus: instruction fetch and data load/store. Each 16-bit access is serialized as a command byte, two address bytes, and two data bytes, using the external ready handshakes and the bus_pc/bus_mar/bus_mdr tag outputs. Sits between cpu_core's control unit and the chip I/O pins.

Parameters:
STARVE_LIMIT, 4, consecutive mem grants allowed while fetch_req is pending before fetch is forced (>=1)
TIMEOUT_CYCLES, 255, wait-cycle limit per byte phase (used only with BUS_TIMEOUT_EN)

Ports:
clk  in  1  system clock
rst_n  in  1  synchronous active-low reset
fetch_req  in  1  fetch request; held with fetch_addr until fetch_done
fetch_addr  in  16  fetch address
fetch_gnt  out  1  one-cycle pulse: fetch accepted
fetch_done  out  1  one-cycle pulse: fetch complete, rdata valid
mem_req  in  1  data request; held with mem_we/addr/wdata until mem_done
mem_we  in  1  1=store, 0=load
mem_addr  in  16  data address
mem_wdata  in  16  store data
mem_gnt  out  1  one-cycle pulse: mem accepted
mem_done  out  1  one-cycle pulse: mem complete
rdata  out  16  last read data
err  out  1  one-cycle pulse with done on timeout abort
in_bus  in  8  external read byte
ard_data_ready  in  1  in_bus valid this cycle
ard_receive_ready  in  1  external side accepts out_bus this cycle
out_bus  out  8  outgoing byte
bus_pc  out  1  high for the whole fetch transaction (CMD..RD_LO)
bus_mar  out  1  out_bus carries command/address byte
bus_mdr  out  1  out_bus carries command/write-data byte
busy  out  1  state != IDLE

Behaviour:
- Single clock; rst_n sampled on the rising edge. While rst_n=0: state=IDLE; all outputs 0 (including rdata); starve_cnt=0.
- Interface signals are driven by registers.
- States: IDLE, CMD, ADDR_HI, ADDR_LO, WR_HI, WR_LO, RD_HI, RD_LO, DONE.
- IDLE with any request: latch the winner's addr, wdata, we, and is_fetch. Go to CMD. The winner's gnt is high during the first CMD cycle only.
- Arbitration:
  - mem wins over fetch, except when starve_cnt==STARVE_LIMIT and both request; then fetch wins.
  - starve_cnt increments on a mem grant while fetch_req=1 (saturates at STARVE_LIMIT).
  - starve_cnt clears on a fetch grant.
- CMD: out_bus={6'b0,is_fetch,we}; bus_mar=bus_mdr=1.
- ADDR_HI / ADDR_LO: out_bus=addr[15:8] / addr[7:0]; bus_mar=1.
- WR_HI / WR_LO: out_bus=wdata[15:8] / wdata[7:0]; bus_mdr=1.
- Send states (CMD, ADDR_HI, ADDR_LO, WR_HI, WR_LO): advance only on an edge where ard_receive_ready=1. Otherwise hold state, out_bus and tags unchanged.
- After ADDR_LO: go to WR_HI if we=1, else RD_HI.
- RD_HI / RD_LO: out_bus=0, bus_mar=bus_mdr=0. Advance on an edge where ard_data_ready=1, capturing in_bus into a shadow hi/lo byte.
- DONE:
  - Requester's done=1 for one cycle; tags=0; out_bus=0.
  - Reads: rdata updates to the shadow word, visible in the DONE cycle; rdata holds until the next successful read.
  - Next state is IDLE. A new request is sampled in IDLE, so there is at least one idle cycle between transactions.
- Minimum latency, gnt cycle = cycle 1: write done at cycle 6; read done at cycle 6 when ready inputs are held high.
- Ready inputs are ignored in IDLE and DONE.
- A requester dropping req after gnt does not abort the transaction.
- rst_n low mid-transaction: immediate return to IDLE, no done pulse, rdata cleared.
- bus_pc=is_fetch in CMD..RD_LO; 0 in IDLE and DONE.

Optional Feature:
- Macro BUS_TIMEOUT_EN.
- Defined:
  - An 8+ bit wait counter clears on every state change and increments on each stalled cycle in a send or read state.
  - When the counter reaches TIMEOUT_CYCLES: go to DONE with err=1 alongside done; rdata unchanged; starve_cnt rules unaffected.
- Undefined: waits are unbounded; err tied to 0; no counter logic.

Test Plan:
- Store: mem_req, we=1, addr=0x1234, wdata=0xBEEF, receive_ready=1 -> out_bus 0x01,0x12,0x34,0xBE,0xEF on cycles 1-5 (tags mar+mdr, mar, mar, mdr, mdr); mem_done at cycle 6; bus_pc=0.
- Fetch: fetch_addr=0x0040; data_ready pulses with in_bus 0xA5 then 0x3C -> cmd byte 0x02; bus_pc high cycles 1-5; rdata=0xA53C with fetch_done.
- Stall: ard_receive_ready=0 for 3 cycles during ADDR_LO of addr 0x1234 -> out_bus holds 0x34 with bus_mar=1 for 4 cycles; done delayed by 3 cycles.
- Arbitration: both requests held continuously -> 4 mem grants, then a fetch grant, then mem again; starve_cnt returns to 0 after the fetch grant.
- Reset: rst_n=0 during WR_HI -> next cycle all outputs 0, busy=0, no mem_done; re-issued request completes normally.
- Timeout (BUS_TIMEOUT_EN, TIMEOUT_CYCLES=8): ard_data_ready never asserted in RD_HI -> done+err pulse together; rdata keeps its old value; busy drops one cycle later.
